// File: rtl/id_stage.sv
// Decode stage of the 5-stage LoongArch32 pipeline: registers the fetch payload, decodes it,
// forwards operands, detects load-use hazards and resolves branches back to fetch.
module id_stage #(
  parameter int IF_to_ID_Bus_Size = 64,
  parameter int ID_to_EX_Bus_Size = 139,
  parameter int br_bus_Size       = 34,
  parameter int Fwd_Bus_Size      = 40
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         IF_to_ID_Valid,
  input  logic [IF_to_ID_Bus_Size-1:0] IF_to_ID_Bus,
  output logic                         ID_Allow_in,
  input  logic                         EX_Allow_in,
  output logic                         ID_to_EX_Valid,
  output logic [ID_to_EX_Bus_Size-1:0] ID_to_EX_Bus,
  output logic [br_bus_Size-1:0]       br_bus,
  output logic [4:0]                   rf_raddr1,
  output logic [4:0]                   rf_raddr2,
  input  logic [31:0]                  rf_rdata1,
  input  logic [31:0]                  rf_rdata2,
  input  logic [Fwd_Bus_Size-1:0]      EX_Fwd_Bus,
  input  logic [Fwd_Bus_Size-1:0]      MEM_Fwd_Bus,
  input  logic [Fwd_Bus_Size-1:0]      WB_Fwd_Bus
);

  typedef enum logic [2:0] {ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_PASS = 3'd2} alu_op_e;

  typedef struct packed {
    logic        valid;
    logic        gr_we;
    logic        is_load;
    logic [4:0]  dest;
    logic [31:0] result;
  } fwd_t;

  function automatic logic fwd_hit(input logic v, input logic we, input logic [4:0] d,
                                   input logic [4:0] a);
    return v && we && (d == a) && (a != 5'd0);
  endfunction

  logic        id_valid_q, id_valid_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d;
  logic        ready_go, load_use;
  fwd_t        ex_fwd, mem_fwd, wb_fwd;
  logic        unused_fwd;

  assign ex_fwd     = EX_Fwd_Bus;
  assign mem_fwd    = MEM_Fwd_Bus;
  assign wb_fwd     = WB_Fwd_Bus;
  assign unused_fwd = mem_fwd.is_load ^ wb_fwd.is_load;

  assign ready_go       = !load_use;
  assign ID_Allow_in    = !id_valid_q || (ready_go && EX_Allow_in);
  assign ID_to_EX_Valid = id_valid_q && ready_go;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    id_valid_d = id_valid_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    if (ID_Allow_in) begin
      id_valid_d = IF_to_ID_Valid;
      if (IF_to_ID_Valid) {pc_d, inst_d} = IF_to_ID_Bus;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_valid_q <= 1'b0;
      pc_q       <= '0;
      inst_q     <= '0;
    end else begin
      id_valid_q <= id_valid_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
    end
  end

  logic [4:0] rd, rj, rk;
  logic is_add, is_sub, is_addi, is_ld, is_st, is_lu12i;
  logic is_jirl, is_b, is_bl, is_beq, is_bne, is_branch, uses_r1, uses_r2;

  assign rd        = inst_q[4:0];
  assign rj        = inst_q[9:5];
  assign rk        = inst_q[14:10];
  assign is_add    = inst_q[31:15] == 17'h00020;
  assign is_sub    = inst_q[31:15] == 17'h00022;
  assign is_addi   = inst_q[31:22] == 10'h00a;
  assign is_ld     = inst_q[31:22] == 10'h0a2;
  assign is_st     = inst_q[31:22] == 10'h0a6;
  assign is_lu12i  = inst_q[31:25] == 7'h0a;
  assign is_jirl   = inst_q[31:26] == 6'h13;
  assign is_b      = inst_q[31:26] == 6'h14;
  assign is_bl     = inst_q[31:26] == 6'h15;
  assign is_beq    = inst_q[31:26] == 6'h16;
  assign is_bne    = inst_q[31:26] == 6'h17;
  assign is_branch = is_jirl || is_b || is_bl || is_beq || is_bne;
  assign uses_r1   = is_add || is_sub || is_addi || is_ld || is_st || is_jirl || is_beq || is_bne;
  assign uses_r2   = is_add || is_sub || is_st || is_beq || is_bne;

  assign rf_raddr1 = rj;
  assign rf_raddr2 = (is_add || is_sub) ? rk : rd;

  logic [31:0] op1, op2;

  // Operand bypass: youngest producer wins, r0 is hard-wired to zero.
  always_comb begin
    op1 = rf_rdata1;
    if (rf_raddr1 == 5'd0)                                               op1 = '0;
    else if (fwd_hit(ex_fwd.valid, ex_fwd.gr_we, ex_fwd.dest, rf_raddr1))    op1 = ex_fwd.result;
    else if (fwd_hit(mem_fwd.valid, mem_fwd.gr_we, mem_fwd.dest, rf_raddr1)) op1 = mem_fwd.result;
    else if (fwd_hit(wb_fwd.valid, wb_fwd.gr_we, wb_fwd.dest, rf_raddr1))    op1 = wb_fwd.result;
  end

  always_comb begin
    op2 = rf_rdata2;
    if (rf_raddr2 == 5'd0)                                               op2 = '0;
    else if (fwd_hit(ex_fwd.valid, ex_fwd.gr_we, ex_fwd.dest, rf_raddr2))    op2 = ex_fwd.result;
    else if (fwd_hit(mem_fwd.valid, mem_fwd.gr_we, mem_fwd.dest, rf_raddr2)) op2 = mem_fwd.result;
    else if (fwd_hit(wb_fwd.valid, wb_fwd.gr_we, wb_fwd.dest, rf_raddr2))    op2 = wb_fwd.result;
  end

  assign load_use = id_valid_q && ex_fwd.valid && ex_fwd.gr_we && ex_fwd.is_load &&
                    (ex_fwd.dest != 5'd0) &&
                    ((uses_r1 && ex_fwd.dest == rf_raddr1) || (uses_r2 && ex_fwd.dest == rf_raddr2));

  logic [31:0] si12, imm_u, offs16, offs26;
  assign si12   = {{20{inst_q[21]}}, inst_q[21:10]};
  assign imm_u  = {inst_q[24:5], 12'b0};
  assign offs16 = {{14{inst_q[25]}}, inst_q[25:10], 2'b0};
  assign offs26 = {{4{inst_q[9]}}, inst_q[9:0], inst_q[25:10], 2'b0};

  alu_op_e     alu_op;
  logic [31:0] src1, src2, st_data;
  logic [4:0]  dest;
  logic        wr, gr_we, mem_re, mem_we;

  always_comb begin
    alu_op  = ALU_ADD;
    src1    = '0;
    src2    = '0;
    st_data = '0;
    dest    = '0;
    wr      = 1'b0;
    mem_re  = 1'b0;
    mem_we  = 1'b0;
    if (is_add || is_sub) begin
      alu_op = is_sub ? ALU_SUB : ALU_ADD;
      src1   = op1;
      src2   = op2;
      dest   = rd;
      wr     = 1'b1;
    end else if (is_addi || is_ld) begin
      src1   = op1;
      src2   = si12;
      dest   = rd;
      wr     = 1'b1;
      mem_re = is_ld;
    end else if (is_st) begin
      src1    = op1;
      src2    = si12;
      st_data = op2;
      mem_we  = 1'b1;
    end else if (is_lu12i) begin
      alu_op = ALU_PASS;
      src2   = imm_u;
      dest   = rd;
      wr     = 1'b1;
    end else if (is_jirl || is_bl) begin
      src1 = pc_q;
      src2 = 32'd4;
      dest = is_bl ? 5'd1 : rd;
      wr   = 1'b1;
    end
  end

  assign gr_we        = wr && (dest != 5'd0);
  assign ID_to_EX_Bus = {pc_q, alu_op, src1, src2, st_data, dest, gr_we, mem_re, mem_we};

  logic        br_cond, br_taken;
  logic [31:0] br_tgt;

  assign br_cond  = is_b || is_bl || is_jirl || (is_beq && (op1 == op2)) || (is_bne && (op1 != op2));
  assign br_tgt   = is_jirl ? (op1 + offs16) : (is_beq || is_bne) ? (pc_q + offs16) : (pc_q + offs26);
  // Taken only on the handoff cycle so fetch redirects exactly once.
  assign br_taken = id_valid_q && ready_go && EX_Allow_in && br_cond;
  assign br_bus   = {br_taken, (br_taken ? br_tgt : 32'd0), id_valid_q && is_branch && load_use};

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: scoreboard of expected EX bundles popped on each handoff,
// plus direct checks of stall, backpressure, branch pulse and reset behaviour.
module tb_id_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         IF_to_ID_Valid;
  logic [63:0]  IF_to_ID_Bus;
  logic         ID_Allow_in;
  logic         EX_Allow_in;
  logic         ID_to_EX_Valid;
  logic [138:0] ID_to_EX_Bus;
  logic [33:0]  br_bus;
  logic [4:0]   rf_raddr1, rf_raddr2;
  logic [31:0]  rf_rdata1, rf_rdata2;
  logic [39:0]  EX_Fwd_Bus, MEM_Fwd_Bus, WB_Fwd_Bus;
  logic [31:0]  rf [32];

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  alu;
    logic [31:0] src1, src2, st_data;
    logic [4:0]  dest;
    logic        we, re, me, taken;
    logic [31:0] target;
    bit          chk_s1, chk_s2, chk_dst, chk_st;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;

  id_stage dut (
    .clk(clk), .reset(reset),
    .IF_to_ID_Valid(IF_to_ID_Valid), .IF_to_ID_Bus(IF_to_ID_Bus),
    .ID_Allow_in(ID_Allow_in), .EX_Allow_in(EX_Allow_in),
    .ID_to_EX_Valid(ID_to_EX_Valid), .ID_to_EX_Bus(ID_to_EX_Bus),
    .br_bus(br_bus),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .EX_Fwd_Bus(EX_Fwd_Bus), .MEM_Fwd_Bus(MEM_Fwd_Bus), .WB_Fwd_Bus(WB_Fwd_Bus)
  );

  always #5 clk = ~clk;

  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [39:0] fwd(input logic v, input logic we, input logic ld,
                                      input logic [4:0] d, input logic [31:0] r);
    return {v, we, ld, d, r};
  endfunction

  function automatic logic [31:0] enc_3r(input logic [16:0] op, input logic [4:0] rd,
                                         input logic [4:0] rj, input logic [4:0] rk);
    return {op, rk, rj, rd};
  endfunction

  function automatic logic [31:0] enc_ri12(input logic [9:0] op, input logic [4:0] rd,
                                           input logic [4:0] rj, input logic [11:0] imm);
    return {op, imm, rj, rd};
  endfunction

  function automatic logic [31:0] enc_br(input logic [5:0] op, input logic [4:0] rj,
                                         input logic [4:0] rd, input logic [15:0] offs);
    return {op, offs, rj, rd};
  endfunction

  function automatic exp_t mk(input logic [31:0] pc, input logic [2:0] alu, input logic [31:0] s1,
                              input logic [31:0] s2, input logic [4:0] dest, input logic we);
    exp_t e;
    e.pc = pc; e.alu = alu; e.src1 = s1; e.src2 = s2; e.st_data = '0; e.dest = dest;
    e.we = we; e.re = 1'b0; e.me = 1'b0; e.taken = 1'b0; e.target = '0;
    e.chk_s1 = 1'b1; e.chk_s2 = 1'b1; e.chk_dst = 1'b1; e.chk_st = 1'b0;
    return e;
  endfunction

  // Scoreboard consumer: every accepted handoff must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && ID_to_EX_Valid && EX_Allow_in) begin
      if (sb.size() == 0) begin
        check("unexpected_issue", 64'd1, 64'd0);
      end else begin
        e_mon = sb.pop_front();
        check("pc", ID_to_EX_Bus[138:107], e_mon.pc);
        check("gr_we", ID_to_EX_Bus[2], e_mon.we);
        check("mem_re", ID_to_EX_Bus[1], e_mon.re);
        check("mem_we", ID_to_EX_Bus[0], e_mon.me);
        check("br_taken", br_bus[33], e_mon.taken);
        check("br_target", br_bus[32:1], e_mon.target);
        check("br_stall", br_bus[0], 1'b0);
        if (e_mon.chk_s1) check("src1", ID_to_EX_Bus[103:72], e_mon.src1);
        if (e_mon.chk_s2) begin
          check("alu_op", ID_to_EX_Bus[106:104], e_mon.alu);
          check("src2", ID_to_EX_Bus[71:40], e_mon.src2);
        end
        if (e_mon.chk_dst) check("dest", ID_to_EX_Bus[7:3], e_mon.dest);
        if (e_mon.chk_st) check("st_data", ID_to_EX_Bus[39:8], e_mon.st_data);
      end
    end
  end

  task automatic send(input logic [31:0] pc, input logic [31:0] inst);
    @(posedge clk); #1;
    IF_to_ID_Valid = 1'b1;
    IF_to_ID_Bus   = {pc, inst};
    @(posedge clk); #1;
    IF_to_ID_Valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    reset = 1'b1; IF_to_ID_Valid = 1'b0; IF_to_ID_Bus = '0; EX_Allow_in = 1'b1;
    EX_Fwd_Bus = '0; MEM_Fwd_Bus = '0; WB_Fwd_Bus = '0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rf[1] = 32'd5; rf[2] = 32'd7;

    repeat (2) @(negedge clk);
    check("rst_allow_in", ID_Allow_in, 1'b1);
    check("rst_valid", ID_to_EX_Valid, 1'b0);
    check("rst_br_bus", br_bus, 34'd0);
    check("rst_bus_hi", ID_to_EX_Bus[138:72], 67'd0);
    check("rst_bus_lo", ID_to_EX_Bus[71:0], 72'd0);
    check("rst_raddr", {rf_raddr1, rf_raddr2}, 10'd0);
    reset = 1'b0;

    // add.w r3,r1,r2 from the regfile
    sb.push_back(mk(32'h1c000000, 3'd0, 32'd5, 32'd7, 5'd3, 1'b1));
    send(32'h1c000000, enc_3r(17'h00020, 5'd3, 5'd1, 5'd2));
    wait_drain("add_drain");
    @(negedge clk);
    check("add_single_issue", ID_to_EX_Valid, 1'b0);

    // EX beats MEM for r1
    EX_Fwd_Bus = fwd(1, 1, 0, 5'd1, 32'h10); MEM_Fwd_Bus = fwd(1, 1, 0, 5'd1, 32'h20);
    sb.push_back(mk(32'h1c000004, 3'd0, 32'h10, 32'd7, 5'd3, 1'b1));
    send(32'h1c000004, enc_3r(17'h00020, 5'd3, 5'd1, 5'd2));
    wait_drain("fwd_ex_drain");

    // EX writing r0 must not forward
    EX_Fwd_Bus = fwd(1, 1, 0, 5'd0, 32'h10); MEM_Fwd_Bus = '0;
    sb.push_back(mk(32'h1c000008, 3'd0, 32'd5, 32'd7, 5'd3, 1'b1));
    send(32'h1c000008, enc_3r(17'h00020, 5'd3, 5'd1, 5'd2));
    wait_drain("fwd_r0_drain");

    // MEM for r2, WB for r1
    EX_Fwd_Bus = '0; MEM_Fwd_Bus = fwd(1, 1, 0, 5'd2, 32'h20); WB_Fwd_Bus = fwd(1, 1, 0, 5'd1, 32'h40);
    sb.push_back(mk(32'h1c00000c, 3'd0, 32'h40, 32'h20, 5'd3, 1'b1));
    send(32'h1c00000c, enc_3r(17'h00020, 5'd3, 5'd1, 5'd2));
    wait_drain("fwd_mem_wb_drain");
    MEM_Fwd_Bus = '0; WB_Fwd_Bus = '0;

    // add.w r0,r0,r2: r0 reads 0 despite a nonzero regfile entry, no write
    rf[0] = 32'hdeadbeef; EX_Fwd_Bus = fwd(1, 1, 0, 5'd0, 32'h99);
    sb.push_back(mk(32'h1c000010, 3'd0, 32'd0, 32'd7, 5'd0, 1'b0));
    send(32'h1c000010, enc_3r(17'h00020, 5'd0, 5'd0, 5'd2));
    wait_drain("r0_drain");
    EX_Fwd_Bus = '0;

    // sub.w r8,r1,r2
    sb.push_back(mk(32'h1c000014, 3'd1, 32'd5, 32'd7, 5'd8, 1'b1));
    send(32'h1c000014, enc_3r(17'h00022, 5'd8, 5'd1, 5'd2));
    wait_drain("sub_drain");

    // load-use: ld.w r4 in EX, addi.w r5,r4,1 in ID
    EX_Fwd_Bus = fwd(1, 1, 1, 5'd4, 32'h7777);
    sb.push_back(mk(32'h1c000018, 3'd0, 32'd9, 32'd1, 5'd5, 1'b1));
    send(32'h1c000018, enc_ri12(10'h00a, 5'd5, 5'd4, 12'd1));
    @(negedge clk);
    check("lu_valid", ID_to_EX_Valid, 1'b0);
    check("lu_allow_in", ID_Allow_in, 1'b0);
    check("lu_br_bus", br_bus, 34'd0);
    @(posedge clk); #1;
    EX_Fwd_Bus = fwd(1, 1, 0, 5'd4, 32'd9);
    @(negedge clk);
    check("lu_release_allow", ID_Allow_in, 1'b1);
    wait_drain("lu_drain");

    // lu12i.w does not read r4, so a load to r4 must not stall it
    EX_Fwd_Bus = fwd(1, 1, 1, 5'd4, 32'd0);
    e = mk(32'h1c00001c, 3'd2, 32'd0, 32'h12345000, 5'd4, 1'b1);
    e.chk_s1 = 1'b0;
    sb.push_back(e);
    send(32'h1c00001c, {7'h0a, 20'h12345, 5'd4});
    @(negedge clk);
    check("lu12i_no_stall", ID_to_EX_Valid, 1'b1);
    wait_drain("lu12i_drain");
    EX_Fwd_Bus = '0;

    // beq r1,r2,+8 taken
    rf[1] = 32'd3; rf[2] = 32'd3;
    e = mk(32'h1c000000, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    e.chk_s1 = 1'b0; e.chk_s2 = 1'b0; e.chk_dst = 1'b0;
    e.taken = 1'b1; e.target = 32'h1c000008;
    sb.push_back(e);
    send(32'h1c000000, enc_br(6'h16, 5'd1, 5'd2, 16'd2));
    wait_drain("beq_drain");
    @(negedge clk);
    check("beq_pulse", br_bus[33], 1'b0);

    // beq not taken
    rf[2] = 32'd4;
    e.taken = 1'b0; e.target = 32'd0;
    sb.push_back(e);
    send(32'h1c000000, enc_br(6'h16, 5'd1, 5'd2, 16'd2));
    wait_drain("beq_nt_drain");

    // bl +0x100 under 3 cycles of EX backpressure
    EX_Allow_in = 1'b0;
    e = mk(32'h1c000010, 3'd0, 32'h1c000010, 32'd4, 5'd1, 1'b1);
    e.taken = 1'b1; e.target = 32'h1c000110;
    sb.push_back(e);
    send(32'h1c000010, {6'h15, 16'h0040, 10'd0});
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bl_hold_taken", br_bus[33], 1'b0);
      check("bl_hold_valid", ID_to_EX_Valid, 1'b1);
      check("bl_hold_allow", ID_Allow_in, 1'b0);
      check("bl_hold_pc", ID_to_EX_Bus[138:107], 32'h1c000010);
    end
    @(posedge clk); #1;
    EX_Allow_in = 1'b1;
    wait_drain("bl_drain");

    // jirl r1,r5,+16
    rf[5] = 32'h1c001000;
    e = mk(32'h1c000020, 3'd0, 32'h1c000020, 32'd4, 5'd1, 1'b1);
    e.taken = 1'b1; e.target = 32'h1c001010;
    sb.push_back(e);
    send(32'h1c000020, enc_br(6'h13, 5'd5, 5'd1, 16'd4));
    wait_drain("jirl_drain");

    // st.w r6,r7,8 with r6 forwarded from WB
    rf[6] = 32'habc; rf[7] = 32'h100; WB_Fwd_Bus = fwd(1, 1, 0, 5'd6, 32'h55);
    e = mk(32'h1c000030, 3'd0, 32'h100, 32'd8, 5'd0, 1'b0);
    e.chk_dst = 1'b0; e.chk_st = 1'b1; e.st_data = 32'h55; e.me = 1'b1;
    sb.push_back(e);
    send(32'h1c000030, enc_ri12(10'h0a6, 5'd6, 5'd7, 12'd8));
    wait_drain("st_drain");
    WB_Fwd_Bus = '0;

    // reset asserted while a branch sits in a load-use stall
    EX_Fwd_Bus = fwd(1, 1, 1, 5'd4, 32'd0);
    send(32'h1c000040, enc_br(6'h16, 5'd4, 5'd2, 16'd2));
    @(negedge clk);
    check("stall_allow_in", ID_Allow_in, 1'b0);
    check("stall_br_bus", br_bus, 34'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_valid", ID_to_EX_Valid, 1'b0);
    check("rst_mid_br_bus", br_bus, 34'd0);
    check("rst_mid_allow_in", ID_Allow_in, 1'b1);
    check("rst_mid_bus_pc", ID_to_EX_Bus[138:107], 32'd0);
    @(negedge clk);
    reset = 1'b0; EX_Fwd_Bus = '0;
    repeat (3) @(negedge clk);
    check("final_idle", ID_to_EX_Valid, 1'b0);
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
